// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for mem_bus_arbiter: FSM states, owner encoding, latched bus request.
// The grant function changes behaviour when MEM_ARB_ROUND_ROBIN_EN is defined.
package mem_bus_arbiter_pkg;

  localparam int ARB_ADDR_W = 64;
  localparam int ARB_DATA_W = 64;
  localparam int ARB_STRB_W = ARB_DATA_W / 8;

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} arb_state_e;

  typedef enum logic {OWN_I, OWN_D} arb_owner_e;

  typedef struct packed {
    logic                  write;
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_DATA_W-1:0] wdata;
    logic [ARB_STRB_W-1:0] strobe;
  } bus_req_t;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // On a tie the requester that did not own the last grant wins.
  function automatic arb_owner_e arb_pick(input logic i_valid, input logic d_valid,
                                          input arb_owner_e last_owner);
    if (i_valid && d_valid) return (last_owner == OWN_I) ? OWN_D : OWN_I;
    return d_valid ? OWN_D : OWN_I;
  endfunction
`else
  function automatic arb_owner_e arb_pick(input logic d_valid);
    return d_valid ? OWN_D : OWN_I;
  endfunction
`endif

endpackage

// File: rtl/mem_bus_arbiter.sv
// Two-requester (fetch / data) arbiter for the single core memory bus.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin ties; otherwise D has fixed priority.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = ARB_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req_valid,
  input  logic [ADDR_W-1:0] i_req_addr,
  output logic              i_resp_valid,
  output logic [DATA_W-1:0] i_resp_data,
  output logic              i_stall,
  input  logic              d_req_valid,
  input  logic              d_req_write,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [DATA_W-1:0] d_req_wdata,
  input  logic [DATA_W/8-1:0] d_req_strobe,
  output logic              d_resp_valid,
  output logic [DATA_W-1:0] d_resp_data,
  output logic              d_stall,
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic              bus_req_write,
  output logic [ADDR_W-1:0] bus_req_addr,
  output logic [DATA_W-1:0] bus_req_wdata,
  output logic [DATA_W/8-1:0] bus_req_strobe,
  input  logic              bus_resp_valid,
  input  logic [DATA_W-1:0] bus_resp_data
);

  arb_state_e        state_q, state_d;
  arb_owner_e        owner_q, owner_d;
  bus_req_t          req_q, req_d;
  logic              i_rv_q, i_rv_d, d_rv_q, d_rv_d;
  logic [DATA_W-1:0] i_rd_q, i_rd_d, d_rd_q, d_rd_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  arb_owner_e        last_q, last_d;
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    req_d   = req_q;
    i_rv_d  = 1'b0;
    d_rv_d  = 1'b0;
    i_rd_d  = i_rd_q;
    d_rd_d  = d_rd_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_d  = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_req_valid || d_req_valid) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
          owner_d = arb_pick(i_req_valid, d_req_valid, last_q);
          last_d  = owner_d;
`else
          owner_d = arb_pick(d_req_valid);
`endif
          // Reads always carry full strobes on the bus.
          if (owner_d == OWN_D) begin
            req_d.write  = d_req_write;
            req_d.addr   = d_req_addr;
            req_d.wdata  = d_req_wdata;
            req_d.strobe = d_req_write ? d_req_strobe : '1;
          end else begin
            req_d.write  = 1'b0;
            req_d.addr   = i_req_addr;
            req_d.wdata  = '0;
            req_d.strobe = '1;
          end
          state_d = REQ;
        end
      end
      REQ: if (bus_req_ready) state_d = RESP;
      RESP: begin
        if (bus_resp_valid) begin
          state_d = DONE;
          if (owner_q == OWN_D) begin
            d_rv_d = 1'b1;
            d_rd_d = bus_resp_data;
          end else begin
            i_rv_d = 1'b1;
            i_rd_d = bus_resp_data;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= OWN_I;
      req_q   <= '0;
      i_rv_q  <= 1'b0;
      d_rv_q  <= 1'b0;
      i_rd_q  <= '0;
      d_rd_q  <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_q  <= OWN_I;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      req_q   <= req_d;
      i_rv_q  <= i_rv_d;
      d_rv_q  <= d_rv_d;
      i_rd_q  <= i_rd_d;
      d_rd_q  <= d_rd_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_q  <= last_d;
`endif
    end
  end

  assign bus_req_valid  = (state_q == REQ);
  assign bus_req_write  = req_q.write;
  assign bus_req_addr   = req_q.addr;
  assign bus_req_wdata  = req_q.wdata;
  assign bus_req_strobe = req_q.strobe;

  assign i_resp_valid = i_rv_q;
  assign i_resp_data  = i_rd_q;
  assign d_resp_valid = d_rv_q;
  assign d_resp_data  = d_rd_q;

  // Stalls follow the live request so the pipeline releases in the response cycle.
  assign i_stall = i_req_valid & ~i_rv_q;
  assign d_stall = d_req_valid & ~d_rv_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios with literal expectations, then random
// traffic checked every cycle against a transaction-level model (MEM_ARB_ROUND_ROBIN_EN aware).
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req_valid = 1'b0;
  logic [63:0] i_req_addr = '0;
  logic        i_resp_valid;
  logic [63:0] i_resp_data;
  logic        i_stall;
  logic        d_req_valid = 1'b0;
  logic        d_req_write = 1'b0;
  logic [63:0] d_req_addr = '0;
  logic [63:0] d_req_wdata = '0;
  logic [7:0]  d_req_strobe = '0;
  logic        d_resp_valid;
  logic [63:0] d_resp_data;
  logic        d_stall;
  logic        bus_req_valid;
  logic        bus_req_ready = 1'b0;
  logic        bus_req_write;
  logic [63:0] bus_req_addr;
  logic [63:0] bus_req_wdata;
  logic [7:0]  bus_req_strobe;
  logic        bus_resp_valid = 1'b0;
  logic [63:0] bus_resp_data = '0;

  mem_bus_arbiter dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .i_req_addr(i_req_addr),
    .i_resp_valid(i_resp_valid), .i_resp_data(i_resp_data), .i_stall(i_stall),
    .d_req_valid(d_req_valid), .d_req_write(d_req_write), .d_req_addr(d_req_addr),
    .d_req_wdata(d_req_wdata), .d_req_strobe(d_req_strobe),
    .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data), .d_stall(d_stall),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
    .bus_req_write(bus_req_write), .bus_req_addr(bus_req_addr),
    .bus_req_wdata(bus_req_wdata), .bus_req_strobe(bus_req_strobe),
    .bus_resp_valid(bus_resp_valid), .bus_resp_data(bus_resp_data)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Transaction-level model: one outstanding transaction, tracked by three milestones.
  logic        m_active = 1'b0, m_accepted = 1'b0, m_respond = 1'b0, m_owner_d = 1'b0;
  logic        m_write = 1'b0;
  logic [63:0] m_addr = '0, m_wdata = '0, m_i_data = '0, m_d_data = '0;
  logic [7:0]  m_strobe = '0;
  logic        pick_d;
  logic        e_brv, e_irv = 1'b0, e_drv = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic        m_last_d = 1'b0;
`endif

  always @(negedge clk) begin
    if (chk_en) begin
      e_brv = m_active && !m_accepted;
      e_irv = m_respond && !m_owner_d;
      e_drv = m_respond && m_owner_d;
      check("bus_req_valid", bus_req_valid, e_brv);
      if (e_brv) begin
        check("bus_req_addr", bus_req_addr, m_addr);
        check("bus_req_write", bus_req_write, m_write);
        check("bus_req_strobe", bus_req_strobe, m_strobe);
        if (m_write) check("bus_req_wdata", bus_req_wdata, m_wdata);
      end
      check("i_resp_valid", i_resp_valid, e_irv);
      check("d_resp_valid", d_resp_valid, e_drv);
      check("i_resp_data", i_resp_data, m_i_data);
      check("d_resp_data", d_resp_data, m_d_data);
      check("i_stall", i_stall, i_req_valid && !e_irv);
      check("d_stall", d_stall, d_req_valid && !e_drv);
      if (rst) begin
        m_active = 0; m_accepted = 0; m_respond = 0; m_owner_d = 0;
        m_write = 0; m_addr = '0; m_wdata = '0; m_strobe = '0;
        m_i_data = '0; m_d_data = '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        m_last_d = 0;
`endif
      end else if (m_respond) begin
        m_active = 0; m_accepted = 0; m_respond = 0;
      end else if (!m_active) begin
        if (i_req_valid || d_req_valid) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
          pick_d = d_req_valid && (!i_req_valid || !m_last_d);
          m_last_d = pick_d;
`else
          pick_d = d_req_valid;
`endif
          m_owner_d = pick_d;
          m_active = 1;
          m_write  = pick_d ? d_req_write : 1'b0;
          m_addr   = pick_d ? d_req_addr : i_req_addr;
          m_wdata  = d_req_wdata;
          m_strobe = (pick_d && d_req_write) ? d_req_strobe : 8'hFF;
        end
      end else if (!m_accepted) begin
        if (bus_req_ready) m_accepted = 1;
      end else if (bus_resp_valid) begin
        m_respond = 1;
        if (m_owner_d) m_d_data = bus_resp_data;
        else m_i_data = bus_resp_data;
      end
    end
  end

  logic [63:0] got_q[$];
  logic [63:0] rr_exp[3];

  initial begin
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    smp();
    check("reset_bus_req_valid", bus_req_valid, 0);
    check("reset_d_resp_valid", d_resp_valid, 0);
    tick(); rst = 0;

    // Single load: 3-cycle minimum latency.
    tick(); d_req_valid = 1; d_req_write = 0; d_req_addr = 64'h8000_0010;
    smp(); check("t1_c0_d_stall", d_stall, 1); check("t1_c0_brv", bus_req_valid, 0);
    tick(); bus_req_ready = 1;
    smp(); check("t1_c1_brv", bus_req_valid, 1); check("t1_c1_addr", bus_req_addr, 64'h8000_0010);
    check("t1_c1_strobe", bus_req_strobe, 8'hFF); check("t1_c1_write", bus_req_write, 0);
    tick(); bus_req_ready = 0; bus_resp_valid = 1; bus_resp_data = 64'hDEAD_BEEF;
    smp(); check("t1_c2_brv", bus_req_valid, 0); check("t1_c2_d_stall", d_stall, 1);
    tick(); bus_resp_valid = 0;
    smp(); check("t1_c3_d_rv", d_resp_valid, 1); check("t1_c3_d_rd", d_resp_data, 64'hDEAD_BEEF);
    check("t1_c3_d_stall", d_stall, 0); check("t1_c3_i_rv", i_resp_valid, 0);
    tick(); d_req_valid = 0;
    smp(); check("t1_c4_d_rv", d_resp_valid, 0);

    // Conflict, then backpressure on the I transaction.
    tick(); i_req_valid = 1; i_req_addr = 64'h1000;
    d_req_valid = 1; d_req_write = 1; d_req_addr = 64'h2000; d_req_wdata = 64'h55; d_req_strobe = 8'h01;
    smp(); check("t2_c0_i_stall", i_stall, 1);
    tick(); bus_req_ready = 1;
    smp(); check("t2_c1_brv", bus_req_valid, 1); check("t2_c1_write", bus_req_write, 1);
    check("t2_c1_addr", bus_req_addr, 64'h2000); check("t2_c1_wdata", bus_req_wdata, 64'h55);
    check("t2_c1_strobe", bus_req_strobe, 8'h01);
    tick(); bus_req_ready = 0; bus_resp_valid = 1; bus_resp_data = 64'h0;
    smp();
    tick(); bus_resp_valid = 0;
    smp(); check("t2_c3_d_rv", d_resp_valid, 1); check("t2_c3_i_stall", i_stall, 1);
    tick(); d_req_valid = 0;
    smp(); check("t2_c4_brv", bus_req_valid, 0); check("t2_c4_i_stall", i_stall, 1);
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k == 1) i_req_addr = 64'h2222;
      smp();
      check("t2_bp_brv", bus_req_valid, 1); check("t2_bp_addr", bus_req_addr, 64'h1000);
      check("t2_bp_write", bus_req_write, 0); check("t2_bp_strobe", bus_req_strobe, 8'hFF);
      check("t2_bp_i_stall", i_stall, 1);
    end
    tick(); bus_req_ready = 1;
    smp(); check("t2_c9_addr", bus_req_addr, 64'h1000);
    tick(); bus_req_ready = 0; bus_resp_valid = 1; bus_resp_data = 64'h1234;
    smp(); check("t2_c10_i_stall", i_stall, 1);
    tick(); bus_resp_valid = 0;
    smp(); check("t2_c11_i_rv", i_resp_valid, 1); check("t2_c11_i_rd", i_resp_data, 64'h1234);
    check("t2_c11_d_rv", d_resp_valid, 0); check("t2_c11_i_stall", i_stall, 0);
    tick(); i_req_valid = 0;

    // Reset while waiting for the response, then a stray response in IDLE.
    tick(); d_req_valid = 1; d_req_write = 0; d_req_addr = 64'h3000;
    tick(); bus_req_ready = 1;
    tick(); bus_req_ready = 0; rst = 1;
    smp(); check("t3_c2_brv", bus_req_valid, 0);
    tick(); rst = 0; d_req_valid = 0; bus_resp_valid = 1; bus_resp_data = 64'hBAD;
    smp(); check("t3_c3_brv", bus_req_valid, 0); check("t3_c3_d_rv", d_resp_valid, 0);
    check("t3_c3_addr", bus_req_addr, 0); check("t3_c3_strobe", bus_req_strobe, 0);
    check("t3_c3_i_rd", i_resp_data, 0); check("t3_c3_d_rd", d_resp_data, 0);
    tick(); bus_resp_valid = 0;
    smp(); check("t3_c4_d_rv", d_resp_valid, 0); check("t3_c4_i_rv", i_resp_valid, 0);

    // Both requesters valid for three back-to-back transactions.
    tick(); i_req_valid = 1; i_req_addr = 64'h100; d_req_valid = 1; d_req_addr = 64'h200;
    bus_req_ready = 1; bus_resp_valid = 1; bus_resp_data = 64'h77;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) tick();
      smp();
      if (bus_req_valid) got_q.push_back(bus_req_addr);
    end
    tick(); i_req_valid = 0; d_req_valid = 0; bus_req_ready = 0; bus_resp_valid = 0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    rr_exp[0] = 64'h200; rr_exp[1] = 64'h100; rr_exp[2] = 64'h200;
`else
    rr_exp[0] = 64'h200; rr_exp[1] = 64'h200; rr_exp[2] = 64'h200;
`endif
    check("rr_count", got_q.size(), 3);
    for (int k = 0; k < 3; k++)
      check("rr_grant", (k < got_q.size()) ? got_q[k] : 64'hFFFF_FFFF_FFFF_FFFF, rr_exp[k]);

    // Random traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      tick();
      rst = ($urandom_range(0, 399) == 0);
      bus_req_ready = ($urandom_range(0, 9) < 6);
      bus_resp_valid = ($urandom_range(0, 1) == 1);
      bus_resp_data = rnd64();
      if (i_req_valid && e_irv) begin
        i_req_valid = ($urandom_range(0, 1) == 1); i_req_addr = rnd64();
      end else if (!i_req_valid) begin
        i_req_valid = ($urandom_range(0, 2) == 0); i_req_addr = rnd64();
      end else if ($urandom_range(0, 7) == 0) begin
        i_req_addr = rnd64();
      end
      if ((d_req_valid && e_drv) || !d_req_valid || $urandom_range(0, 7) == 0) begin
        if (d_req_valid && e_drv) d_req_valid = ($urandom_range(0, 1) == 1);
        else if (!d_req_valid) d_req_valid = ($urandom_range(0, 2) == 0);
        d_req_write = $urandom_range(0, 1);
        d_req_addr = rnd64(); d_req_wdata = rnd64(); d_req_strobe = 8'($urandom);
      end
    end
    tick(); rst = 0; i_req_valid = 0; d_req_valid = 0; bus_req_ready = 0; bus_resp_valid = 0;
    repeat (6) tick();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
